// File: rtl/mul8_seq_ctrl.sv
// ---------------------------------------------------------------------------
// mul8_seq_ctrl
//   Sequencing controller that builds an unsigned 8x8 -> 16-bit product by
//   time-multiplexing an external combinational 4x4 multiplier over four
//   partial-product steps. A valid/ready handshake is used on both the operand
//   side and the result side.
//
//   Parameters:
//     ZERO_BYPASS - when 1, an operand pair with a zero operand skips the
//                   multiply steps and reports product 0 one cycle after accept.
//
//   Ports:
//     clk        in   rising-edge clock
//     rst_n      in   asynchronous active-low reset
//     in_valid   in   operand pair valid
//     in_ready   out  operands can be accepted (IDLE only)
//     a, b       in   8-bit unsigned operands
//     out_valid  out  product valid, held until accepted
//     out_ready  in   sink accepts product
//     product    out  16-bit registered result
//     busy       out  operation in progress (MUL or DONE)
//     mul_a      out  nibble operand to the 4x4 multiplier
//     mul_b      out  nibble operand to the 4x4 multiplier
//     mul_p      in   8-bit combinational product from the 4x4 multiplier
// ---------------------------------------------------------------------------
module mul8_seq_ctrl #(
    parameter logic ZERO_BYPASS = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] product,
    output logic        busy,
    output logic [3:0]  mul_a,
    output logic [3:0]  mul_b,
    input  logic [7:0]  mul_p
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      state_q,     state_d;
    logic [1:0]  step_q,      step_d;
    logic [15:0] acc_q,       acc_d;
    logic [7:0]  op_a_q,      op_a_d;
    logic [7:0]  op_b_q,      op_b_d;
    logic [15:0] product_q,   product_d;
    logic        out_valid_q, out_valid_d;
    logic        in_ready_q,  in_ready_d;
    logic        busy_q,      busy_d;

    logic [3:0]  mul_a_s;
    logic [3:0]  mul_b_s;
    logic [15:0] pp_shift_s;
    logic [15:0] acc_sum_s;
    logic        zero_op_s;

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign product   = product_q;
    assign busy      = busy_q;
    assign mul_a     = mul_a_s;
    assign mul_b     = mul_b_s;

    // Nibble selection for the current step and alignment of the returned partial product.
    always_comb begin
        mul_a_s    = 4'h0;
        mul_b_s    = 4'h0;
        pp_shift_s = 16'h0000;
        if (state_q == ST_MUL) begin
            case (step_q)
                2'd0: begin
                    mul_a_s    = op_a_q[3:0];
                    mul_b_s    = op_b_q[3:0];
                    pp_shift_s = {8'h00, mul_p};
                end
                2'd1: begin
                    mul_a_s    = op_a_q[7:4];
                    mul_b_s    = op_b_q[3:0];
                    pp_shift_s = {4'h0, mul_p, 4'h0};
                end
                2'd2: begin
                    mul_a_s    = op_a_q[3:0];
                    mul_b_s    = op_b_q[7:4];
                    pp_shift_s = {4'h0, mul_p, 4'h0};
                end
                2'd3: begin
                    mul_a_s    = op_a_q[7:4];
                    mul_b_s    = op_b_q[7:4];
                    pp_shift_s = {mul_p, 8'h00};
                end
                default: begin
                    mul_a_s    = 4'h0;
                    mul_b_s    = 4'h0;
                    pp_shift_s = 16'h0000;
                end
            endcase
        end else begin
            // Operands parked at zero so the multiplier does not toggle when idle.
            mul_a_s    = 4'h0;
            mul_b_s    = 4'h0;
            pp_shift_s = 16'h0000;
        end
    end

    // Accumulator sum; 255*255 fits in 16 bits so no carry-out is kept.
    always_comb begin
        acc_sum_s = acc_q + pp_shift_s;
        zero_op_s = (a == 8'h00) || (b == 8'h00);
    end

    // Next-state and next-output computation for the sequencing FSM.
    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        acc_d       = acc_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        product_d   = product_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;
        busy_d      = busy_q;
        case (state_q)
            ST_IDLE: begin
                in_ready_d  = 1'b1;
                busy_d      = 1'b0;
                out_valid_d = 1'b0;
                if (in_valid && in_ready_q) begin
                    op_a_d     = a;
                    op_b_d     = b;
                    acc_d      = 16'h0000;
                    in_ready_d = 1'b0;
                    busy_d     = 1'b1;
                    step_d     = 2'd0;
                    if ((ZERO_BYPASS == 1'b1) && zero_op_s) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_MUL;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MUL: begin
                acc_d  = acc_sum_s;
                step_d = step_q + 2'd1;
                if (step_q == 2'd3) begin
                    // Final partial product lands in product on the same edge.
                    state_d     = ST_DONE;
                    product_d   = acc_sum_s;
                    out_valid_d = 1'b1;
                end else begin
                    state_d = ST_MUL;
                end
            end
            ST_DONE: begin
                if (!out_valid_q) begin
                    // Only reachable through the zero bypass: publish the cleared acc one cycle after accept.
                    out_valid_d = 1'b1;
                    product_d   = acc_q;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                step_d      = 2'd0;
                acc_d       = 16'h0000;
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                busy_d      = 1'b0;
            end
        endcase
    end

    // State and registered-output flops with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            step_q      <= 2'd0;
            acc_q       <= 16'h0000;
            op_a_q      <= 8'h00;
            op_b_q      <= 8'h00;
            product_q   <= 16'h0000;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            acc_q       <= acc_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            product_q   <= product_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
        end
    end

endmodule

// File: doc/mul8_seq_ctrl.md
Name: mul8_seq_ctrl

Overview:
- Sequencing controller that computes an unsigned 8x8 -> 16-bit product by time-multiplexing the team's existing combinational 4x4 multiplier over four partial-product steps.
- The 4x4 multiplier is instantiated alongside this block, not inside it: this block drives its operand inputs and reads back its 8-bit product.
- Sits between an operand source (valid/ready) and a result sink (valid/ready) in the ALU datapath.

Parameters:
- ZERO_BYPASS, 1, when 1 a zero operand (a==0 or b==0) skips the four multiply steps and presents product 0 on the cycle after accept.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block can accept operands; high only in IDLE.
- a  input  8  multiplicand, unsigned.
- b  input  8  multiplier, unsigned.
- out_valid  output  1  product valid; held until accepted.
- out_ready  input  1  sink accepts product.
- product  output  16  registered result.
- busy  output  1  high in MUL or DONE.
- mul_a  output  4  operand nibble to the 4x4 multiplier.
- mul_b  output  4  operand nibble to the 4x4 multiplier.
- mul_p  input  8  combinational product returned by the 4x4 multiplier.

Behaviour:
- Reset (rst_n low, asynchronous, any state): state=IDLE, step=0, acc=0, op regs=0. Outputs: in_ready=1 (once rst_n is high), out_valid=0, product=0, busy=0, mul_a=0, mul_b=0.
- States: IDLE, MUL, DONE. step is a 2-bit counter used only in MUL.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready: latch a and b into op regs and clear acc.
  - If ZERO_BYPASS=1 and (a==0 or b==0): go to DONE with acc=0.
  - Otherwise go to MUL with step=0.
- MUL (in_ready=0, busy=1): mul_a and mul_b are combinational from step and the op regs. Each cycle, acc <= acc + (mul_p << shift), then step increments.
  - step0: mul_a=a[3:0], mul_b=b[3:0], shift 0.
  - step1: mul_a=a[7:4], mul_b=b[3:0], shift 4.
  - step2: mul_a=a[3:0], mul_b=b[7:4], shift 4.
  - step3: mul_a=a[7:4], mul_b=b[7:4], shift 8. Then go to DONE; the final acc is loaded into product on this same edge.
- Widths: acc is 16 bits. Maximum is 255*255 = 0xFE01, so no overflow is possible and no carry out is required. mul_p is zero-extended before shifting.
- DONE (busy=1, in_ready=0): out_valid=1 and product stable. On out_ready go to IDLE; out_valid drops on that edge.
- Latency:
  - Normal path: accept at edge E0, out_valid high after E4 (4 cycles).
  - Bypass path: out_valid high after E1 (1 cycle).
  - Throughput is one operation per 5 cycles minimum (accept + 4 MUL), plus any DONE wait.
- Backpressure: while out_ready=0 in DONE, product and out_valid hold indefinitely. in_valid is ignored.
- in_valid while in MUL or DONE has no effect. The source must hold its operands; they are not sampled again until IDLE.
- mul_a and mul_b are 0 outside MUL, so the 4x4 multiplier sees no toggling when idle.
- product holds its last value after the DONE handshake until the next load.
- Reset asserted mid-MUL or mid-DONE aborts the operation. No product is emitted and all state returns to reset values.
- Sole arithmetic dependency: mul_p must equal mul_a*mul_b combinationally in the same cycle.

Test Plan:
- a=0x12, b=0x34, out_ready=1 -> mul_a/mul_b sequence (2,4),(1,4),(2,3),(1,3); out_valid 4 cycles after accept; product=0x03A8.
- a=0xFF, b=0xFF -> product=0xFE01, no overflow; then a=0x01, b=0x01 back-to-back -> product=0x0001, second accept no earlier than the cycle after the DONE handshake.
- ZERO_BYPASS=1, a=0x00, b=0xAB -> out_valid 1 cycle after accept, product=0x0000, mul_a/mul_b stay 0. Repeat with ZERO_BYPASS=0 -> 4-cycle path, product=0x0000.
- a=0x0F, b=0xF0, out_ready held 0 for 6 cycles -> product=0x0E10 stable with out_valid=1 throughout; in_valid pulses with new operands during the wait are ignored (in_ready=0).
- Start a=0xA5, b=0x5A; assert rst_n=0 at step2 -> out_valid=0, product=0, state IDLE immediately. After release, a=0x03, b=0x07 -> product=0x0015.
